si_frame_packer: RTL

Serializes one MPEG-1 Layer III stereo frame preamble into the byte stream used by the parsing chain: 4-byte header, optional 2-byte CRC, and 32-byte two-channel side information. It is the transmit-side counterpart of the header finder and side-info parser. The block produces reference byte streams for the parser chain and re-emits edited frames. On a start pulse it latches all fields, then drives bytes out MSB-first over a valid/ready handshake.

---
 rtl/mp3_pkg.sv | 45 ++++
 rtl/si_packer.sv | 74 +++++++
 rtl/si_frame_packer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mp3_pkg.sv
// Shared constants, field widths, FSM state type and header packing for the MPEG-1 Layer III frame packer.
// Latency: n/a (package only).
// Backpressure: n/a.
package mp3_pkg;

   localparam logic [10:0] SYNC_WORD   = 11'h7FF;
   localparam int HDR_BITS             = 32;
   localparam int CRC_BITS             = 16;
   localparam int SI_BITS_2CH          = 256;
   localparam int GRCH_BITS            = 59;
   localparam int FRAME_BITS           = HDR_BITS + CRC_BITS + SI_BITS_2CH;
   localparam int FRAME_BYTES_NOCRC    = 36;
   localparam int FRAME_BYTES_CRC      = 38;
   localparam int CNT_W                = 6;

   // Side-information field widths
   localparam int MDB_W   = 9;
   localparam int PRIV_W  = 3;
   localparam int SCFSI_W = 4;
   localparam int P23_W   = 12;
   localparam int BV_W    = 9;
   localparam int GG_W    = 8;
   localparam int SFC_W   = 4;
   localparam int BT_W    = 2;
   localparam int TS_W    = 5;
   localparam int SBG_W   = 3;
   localparam int RC_W    = 4;
   localparam int R1_W    = 3;   // region1_count bits actually emitted

   typedef enum logic {IDLE, SEND} state_t;

   // 32-bit frame header, MSB first. Private, copyright and original are always 0.
   function automatic logic [HDR_BITS-1:0] pack_header(
      input logic       prot,
      input logic [3:0] bitrate_index,
      input logic [1:0] samp_freq,
      input logic       padding,
      input logic [1:0] mode,
      input logic [1:0] mode_ext,
      input logic [1:0] emphasis);
      return {SYNC_WORD, 2'b11, 2'b01, prot, bitrate_index, samp_freq, padding,
              1'b0, mode, mode_ext, 2'b00, emphasis};
   endfunction

endpackage

// File: rtl/si_packer.sv
// Purely combinational packer: two-channel Layer III side-info fields -> 256-bit vector, MSB first.
// Latency: 0 cycles.  Backpressure: none (no state).
// Ports: field inputs indexed [gr][ch]; si_bits out.
module si_packer
   import mp3_pkg::*;
(
   input  logic [MDB_W-1:0]                  main_data_begin,
   input  logic [PRIV_W-1:0]                 private_bits,
   input  logic [1:0][SCFSI_W-1:0]           scfsi,
   input  logic [1:0][1:0][P23_W-1:0]        part2_3_length,
   input  logic [1:0][1:0][BV_W-1:0]         big_values,
   input  logic [1:0][1:0][GG_W-1:0]         global_gain,
   input  logic [1:0][1:0][SFC_W-1:0]        scalefac_compress,
   input  logic [1:0][1:0]                   window_switching_flag,
   input  logic [1:0][1:0][BT_W-1:0]         block_type,
   input  logic [1:0][1:0]                   mixed_block_flag,
   input  logic [1:0][1:0][2:0][TS_W-1:0]    table_select,
   input  logic [1:0][1:0][2:0][SBG_W-1:0]   subblock_gain,
   input  logic [1:0][1:0][RC_W-1:0]         region0_count,
   input  logic [1:0][1:0][RC_W-1:0]         region1_count,
   input  logic [1:0][1:0]                   preflag,
   input  logic [1:0][1:0]                   scalefac_scale,
   input  logic [1:0][1:0]                   count1table_select,
   output logic [SI_BITS_2CH-1:0]            si_bits
);

   // One [gr][ch] group. Both wsf branches of the middle section are 22 bits,
   // so every group is 59 bits and later groups never shift.
   function automatic logic [GRCH_BITS-1:0] pack_grch(
      input logic [P23_W-1:0]       p23,
      input logic [BV_W-1:0]        bv,
      input logic [GG_W-1:0]        gg,
      input logic [SFC_W-1:0]       sfc,
      input logic                   wsf,
      input logic [BT_W-1:0]        bt,
      input logic                   mbf,
      input logic [2:0][TS_W-1:0]   ts,
      input logic [2:0][SBG_W-1:0]  sbg,
      input logic [RC_W-1:0]        r0,
      input logic [R1_W-1:0]        r1,
      input logic                   pf,
      input logic                   sfs,
      input logic                   c1);
      logic [21:0] mid;
      if (wsf)
         mid = {bt, mbf, ts[0], ts[1], sbg[0], sbg[1], sbg[2]};
      else
         mid = {ts[0], ts[1], ts[2], r0, r1};
      return {p23, bv, gg, sfc, wsf, mid, pf, sfs, c1};
   endfunction

   logic [3:0][GRCH_BITS-1:0] grp;

   for (genvar gr = 0; gr < 2; gr++) begin : g_gr
      for (genvar ch = 0; ch < 2; ch++) begin : g_ch
         assign grp[gr*2+ch] = pack_grch(
            part2_3_length[gr][ch], big_values[gr][ch], global_gain[gr][ch],
            scalefac_compress[gr][ch], window_switching_flag[gr][ch],
            block_type[gr][ch], mixed_block_flag[gr][ch], table_select[gr][ch],
            subblock_gain[gr][ch], region0_count[gr][ch],
            region1_count[gr][ch][R1_W-1:0], preflag[gr][ch],
            scalefac_scale[gr][ch], count1table_select[gr][ch]);
      end
   end

   // region1_count bit 3 has no slot in the bitstream
   logic unused_r1_msb;
   assign unused_r1_msb = ^{region1_count[0][0][3], region1_count[0][1][3],
                            region1_count[1][0][3], region1_count[1][1][3]};

   assign si_bits = {main_data_begin, private_bits, scfsi[0], scfsi[1],
                     grp[0], grp[1], grp[2], grp[3]};

endmodule

// File: rtl/si_frame_packer.sv
// Serializes header + optional CRC + 2ch side info of one Layer III frame into bytes, MSB first.
// Latency: start at edge N -> byte 0 valid from N+1; one byte per cycle while axior=1.
// Backpressure: axior low holds axiod/axiov stable; start while busy is dropped (no queue).
// Ports: clk/rst (async active-low), start + frame fields in, axiod/axiov/axior byte stream, busy, done.
module si_frame_packer
   import mp3_pkg::*;
(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              prot,
   input  logic [3:0]                        bitrate_index,
   input  logic [1:0]                        samp_freq,
   input  logic                              padding,
   input  logic [1:0]                        mode,
   input  logic [1:0]                        mode_ext,
   input  logic [1:0]                        emphasis,
   input  logic [15:0]                       crc_word,
   input  logic [MDB_W-1:0]                  main_data_begin,
   input  logic [PRIV_W-1:0]                 private_bits,
   input  logic [1:0][SCFSI_W-1:0]           scfsi,
   input  logic [1:0][1:0][P23_W-1:0]        part2_3_length,
   input  logic [1:0][1:0][BV_W-1:0]         big_values,
   input  logic [1:0][1:0][GG_W-1:0]         global_gain,
   input  logic [1:0][1:0][SFC_W-1:0]        scalefac_compress,
   input  logic [1:0][1:0]                   window_switching_flag,
   input  logic [1:0][1:0]                   mixed_block_flag,
   input  logic [1:0][1:0]                   preflag,
   input  logic [1:0][1:0]                   scalefac_scale,
   input  logic [1:0][1:0]                   count1table_select,
   input  logic [1:0][1:0][BT_W-1:0]         block_type,
   input  logic [1:0][1:0][2:0][TS_W-1:0]    table_select,
   input  logic [1:0][1:0][2:0][SBG_W-1:0]   subblock_gain,
   input  logic [1:0][1:0][RC_W-1:0]         region0_count,
   input  logic [1:0][1:0][RC_W-1:0]         region1_count,
   output logic [7:0]                        axiod,
   output logic                              axiov,
   input  logic                              axior,
   output logic                              busy,
   output logic                              done
);

   state_t                 state, state_nxt;
   logic [FRAME_BITS-1:0]  sreg;
   logic [CNT_W-1:0]       cnt;
   logic                   load, shift;
   logic [SI_BITS_2CH-1:0] si_bits;
   logic [HDR_BITS-1:0]    hdr_bits;

   si_packer u_si_packer (
      .main_data_begin       (main_data_begin),
      .private_bits          (private_bits),
      .scfsi                 (scfsi),
      .part2_3_length        (part2_3_length),
      .big_values            (big_values),
      .global_gain           (global_gain),
      .scalefac_compress     (scalefac_compress),
      .window_switching_flag (window_switching_flag),
      .block_type            (block_type),
      .mixed_block_flag      (mixed_block_flag),
      .table_select          (table_select),
      .subblock_gain         (subblock_gain),
      .region0_count         (region0_count),
      .region1_count         (region1_count),
      .preflag               (preflag),
      .scalefac_scale        (scalefac_scale),
      .count1table_select    (count1table_select),
      .si_bits               (si_bits)
   );

   assign hdr_bits = pack_header(prot, bitrate_index, samp_freq, padding,
                                 mode, mode_ext, emphasis);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift     = 1'b0;
      done      = 1'b0;
      axiov     = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            axiov = 1'b1;
            busy  = 1'b1;
            if (axior) begin
               shift = 1'b1;
               if (cnt == CNT_W'(1)) begin
                  done      = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Without CRC the side info moves up into the CRC slot; the tail is padding
   // that is never emitted because the count stops at 36.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sreg <= '0;
         cnt  <= '0;
      end else if (load) begin
         sreg <= prot ? {hdr_bits, si_bits, {CRC_BITS{1'b0}}}
                      : {hdr_bits, crc_word, si_bits};
         cnt  <= prot ? CNT_W'(FRAME_BYTES_NOCRC) : CNT_W'(FRAME_BYTES_CRC);
      end else if (shift) begin
         sreg <= {sreg[FRAME_BITS-9:0], 8'h00};
         cnt  <= cnt - CNT_W'(1);
      end
   end

   assign axiod = sreg[FRAME_BITS-1 -: 8];

endmodule
